// File: rtl/maxpool_1_ctrl.sv
// 2x2/stride-2 max-pool sequencer: scans a CH x IN_DIM x IN_DIM map one read per cycle
// and writes one signed window maximum per 2x2 window.
module maxpool_1_ctrl #(
  parameter int bitwidth = 16,
  parameter int CH       = 2,
  parameter int IN_DIM   = 28
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       rd_en,
  output logic [10:0]                rd_addr,
  input  logic signed [bitwidth-1:0] rd_data,
  output logic                       wr_en,
  output logic [8:0]                 wr_addr,
  output logic signed [bitwidth-1:0] wr_data
);
  localparam int OUT_DIM = IN_DIM / 2;
  localparam int CW      = (CH > 1) ? $clog2(CH) : 1;
  localparam int OW      = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int LAST_W  = CH * OUT_DIM * OUT_DIM - 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  // Element tag of the read issued last cycle, consumed with its returning data.
  typedef struct packed {
    logic       vld;
    logic [1:0] q;
    logic [8:0] waddr;
  } tag_t;

  state_t                      state;
  logic [CW-1:0]               c, nc;
  logic [OW-1:0]               i, j, ni, nj;
  logic [1:0]                  q, nq;
  logic                        last, dcnt;
  tag_t                        tag;
  logic signed [bitwidth-1:0]  acc;

  function automatic logic [10:0] raddr(input int c_, input int i_, input int j_, input int q_);
    return 11'(c_*IN_DIM*IN_DIM + (2*i_ + q_/2)*IN_DIM + 2*j_ + q_%2);
  endfunction

  function automatic logic [8:0] waddr(input int c_, input int i_, input int j_);
    return 9'(c_*OUT_DIM*OUT_DIM + i_*OUT_DIM + j_);
  endfunction

  always_comb begin
    nc = c;
    ni = i;
    nj = j;
    nq = q + 2'd1;
    last = (c == CW'(CH-1)) && (i == OW'(OUT_DIM-1)) && (j == OW'(OUT_DIM-1)) && (q == 2'd3);
    if (q == 2'd3) begin
      if (j == OW'(OUT_DIM-1)) begin
        nj = '0;
        if (i == OW'(OUT_DIM-1)) begin
          ni = '0;
          nc = c + CW'(1);
        end else begin
          ni = i + OW'(1);
        end
      end else begin
        nj = j + OW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      c       <= '0;
      i       <= '0;
      j       <= '0;
      q       <= '0;
      dcnt    <= 1'b0;
      tag     <= '0;
      acc     <= '0;
    end else begin
      done    <= 1'b0;
      wr_en   <= 1'b0;
      tag.vld   <= rd_en;
      tag.q     <= q;
      tag.waddr <= waddr(int'(c), int'(i), int'(j));

      if (tag.vld) begin
        case (tag.q)
          2'd0:    acc <= rd_data;
          2'd3: begin
            wr_en   <= 1'b1;
            wr_addr <= tag.waddr;
            wr_data <= (rd_data > acc) ? rd_data : acc;
            done    <= (tag.waddr == 9'(LAST_W));
          end
          default: if (rd_data > acc) acc <= rd_data;
        endcase
      end

      case (state)
        IDLE: if (start) begin
          state   <= RUN;
          busy    <= 1'b1;
          rd_en   <= 1'b1;
          rd_addr <= '0;
          c       <= '0;
          i       <= '0;
          j       <= '0;
          q       <= '0;
        end
        RUN: if (last) begin
          state <= DRAIN;
          rd_en <= 1'b0;
          dcnt  <= 1'b0;
        end else begin
          c       <= nc;
          i       <= ni;
          j       <= nj;
          q       <= nq;
          rd_addr <= raddr(int'(nc), int'(ni), int'(nj), int'(nq));
        end
        DRAIN: if (dcnt) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else begin
          dcnt <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_maxpool_1_ctrl.sv
// Self-checking bench for maxpool_1_ctrl: memory model plus array-based pooling reference.
module tb_maxpool_1_ctrl;
  localparam int IN = 28, OD = 14, CH = 2;
  localparam int NRD = CH*IN*IN, NWR = CH*OD*OD;

  logic clk = 1'b0, rst, start;
  logic busy, done, rd_en, wr_en;
  logic [10:0] rd_addr;
  logic [8:0]  wr_addr;
  logic signed [15:0] rd_data, wr_data;

  logic signed [15:0] mem [0:NRD-1];
  int exp_o [0:NWR-1];
  int got_o [0:NWR-1];
  int n_chk = 0, n_fail = 0;

  maxpool_1_ctrl #(.bitwidth(16), .CH(CH), .IN_DIM(IN)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  // Single-port buffer: one-cycle read latency, garbage on non-read cycles.
  always @(posedge clk)
    rd_data <= rd_en ? mem[rd_addr] : 16'($urandom);

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int in_addr(input int c, input int r, input int col);
    return c*IN*IN + r*IN + col;
  endfunction

  // pat: 0 ramp, 1 max at q1, 2 all min, 3 max at q=k%4, 4 random, 5 small random (ties)
  task automatic fill(input int pat);
    for (int a = 0; a < NRD; a++) begin
      int c, r, col, k, qq, v;
      c = a / (IN*IN); r = (a % (IN*IN)) / IN; col = a % IN;
      k = c*OD*OD + (r/2)*OD + col/2;
      qq = (r%2)*2 + (col%2);
      case (pat)
        0: v = a;
        1: v = (qq == 1) ? 32767 : -32768;
        2: v = -32768;
        3: v = (qq == k%4) ? 5 : -7;
        4: v = int'($signed(16'($urandom)));
        default: v = int'($urandom_range(0, 6)) - 3;
      endcase
      mem[a] = 16'(v);
    end
    for (int c = 0; c < CH; c++)
      for (int i = 0; i < OD; i++)
        for (int j = 0; j < OD; j++) begin
          int m;
          m = int'(mem[in_addr(c, 2*i, 2*j)]);
          for (int d = 1; d < 4; d++)
            if (int'(mem[in_addr(c, 2*i + d/2, 2*j + d%2)]) > m)
              m = int'(mem[in_addr(c, 2*i + d/2, 2*j + d%2)]);
          exp_o[c*OD*OD + i*OD + j] = m;
        end
  endtask

  // Called at a negedge; start is sampled at the next posedge (cycle 0).
  task automatic run_pass(input bit pulses, input bit chain, input int abort_at);
    start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 1571; cyc++) begin
      int n, w, qq, c, i, j;
      @(negedge clk);
      start = 1'b0;
      if (abort_at != 0 && cyc == abort_at + 1) begin
        rst = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rd_en", int'(rd_en), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_rd_addr", int'(rd_addr), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        for (int t = 0; t < 20; t++) begin
          @(negedge clk);
          chk("abort_done", int'(done), 0);
          chk("abort_rd_en", int'(rd_en), 0);
          chk("abort_busy", int'(busy), 0);
        end
        return;
      end
      chk("busy", int'(busy), (cyc <= 1570) ? 1 : 0);
      chk("rd_en", int'(rd_en), (cyc <= NRD) ? 1 : 0);
      if (cyc <= NRD) begin
        n = cyc - 1; w = n / 4; qq = n % 4;
        c = w / (OD*OD); i = (w % (OD*OD)) / OD; j = w % OD;
        chk("rd_addr", int'(rd_addr), in_addr(c, 2*i + qq/2, 2*j + qq%2));
      end
      chk("done", int'(done), (cyc == 1570) ? 1 : 0);
      if (cyc >= 6 && (cyc - 6) % 4 == 0) begin
        w = (cyc - 6) / 4;
        chk("wr_en", int'(wr_en), 1);
        chk("wr_addr", int'(wr_addr), w);
        chk("wr_data", int'(wr_data), exp_o[w]);
        got_o[w] = int'(wr_data);
      end else begin
        chk("wr_en_idle", int'(wr_en), 0);
      end
      if (abort_at == cyc) rst = 1'b1;
      if (pulses && (cyc == 100 || cyc == 1570)) start = 1'b1;
      if (chain && cyc == 1571) start = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_rd_en", int'(rd_en), 0);
    chk("reset_wr_en", int'(wr_en), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_rd_addr", int'(rd_addr), 0);
    chk("reset_wr_data", int'(wr_data), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Ramp with ignored starts at 100/1570, then back-to-back random pass.
    fill(0);
    run_pass(1'b1, 1'b1, 0);
    chk("ramp_out0", got_o[0], 29);
    chk("ramp_out13", got_o[13], 55);
    chk("ramp_out196", got_o[196], 813);
    fill(4);
    run_pass(1'b0, 1'b0, 0);

    fill(1); run_pass(1'b0, 1'b0, 0);
    fill(2); run_pass(1'b0, 1'b0, 0);
    fill(3); run_pass(1'b0, 1'b0, 0);

    // Abort mid-pass, then a clean ramp pass.
    fill(0); run_pass(1'b0, 1'b0, 800);
    run_pass(1'b0, 1'b0, 0);
    chk("post_rst_out0", got_o[0], 29);
    chk("post_rst_out391", got_o[391], 1567);

    fill(5); run_pass(1'b0, 1'b0, 0);
    fill(4); run_pass(1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/maxpool_1_ctrl.md
# maxpool_1_ctrl

Sequencer for the first 2x2/stride-2 max-pooling stage of the LeNet datapath. It walks a 2-channel 28x28 signed feature map held in a single-port input buffer and reads one word per cycle. Each 2x2 window is reduced to its signed maximum, and the 14x14x2 pooled result is written to an output buffer one word per window. It sits between the conv1 result buffer and the conv2 input buffer and is started by the layer scheduler.

## Interface
- bitwidth, 16, signed pixel width
- CH, 2, channel count
- IN_DIM, 28, input rows/cols (even); output dim OUT_DIM = IN_DIM/2
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; honoured only in IDLE
- busy  out  1  high while a pass is in progress
- done  out  1  one-cycle pulse with the final write
- rd_en  out  1  input-buffer read strobe
- rd_addr  out  11  input address = c*IN_DIM*IN_DIM + r*IN_DIM + col
- rd_data  in  bitwidth  signed read data, valid exactly 1 cycle after rd_en
- wr_en  out  1  output-buffer write strobe
- wr_addr  out  9  output address = c*OUT_DIM*OUT_DIM + i*OUT_DIM + j
- wr_data  out  bitwidth  signed window maximum

## Operation
- Reset: state IDLE. busy, done, rd_en, wr_en are 0. rd_addr, wr_addr, wr_data are 0. All counters and the accumulator are 0.
- FSM states:
  - IDLE: on start go to RUN.
  - RUN: on the final read go to DRAIN.
  - DRAIN: holds for exactly 2 cycles, then returns to IDLE.
- Scan order: channel outer, then out row i, then out col j, then window element q = 0..3.
- Window element mapping: q0 = (2i,2j), q1 = (2i,2j+1), q2 = (2i+1,2j), q3 = (2i+1,2j+1).
- RUN issues one read per cycle without gaps: CH*IN_DIM*IN_DIM = 1568 reads.
- Counter wrap: q wraps 3 to 0 and increments j. j wraps at OUT_DIM-1 and increments i. i wraps and increments c. The final read is c=CH-1, i=j=OUT_DIM-1, q=3.
- Data path, with the returned-element index delayed 1 cycle to match read latency:
  - q0 data loads the accumulator.
  - q1..q2 data: acc = (rd_data > acc) ? rd_data : acc, as a signed compare.
  - q3 data: the registered write is launched with wr_data = signed max(acc, rd_data) and wr_addr = the window's output address.
- Width rules: no arithmetic growth; compare only. -32768 and 32767 must be handled exactly.
- start while busy, or in the cycle busy falls, is ignored. start is accepted again from the first IDLE cycle.
- rst in any state aborts the pass. Outputs take their reset values next cycle, no done is issued, and partial output-buffer contents are left as written.
- rd_data is ignored whenever no read was issued the previous cycle.

## Timing
- Cycle 0 is the edge where start is sampled in IDLE.
- Cycle 1: busy=1, rd_en=1, rd_addr=0.
- Read n (0-based) is issued at cycle n+1. Reads occupy cycles 1..1568.
- Window k (0-based) is written at cycle 4k+6. The first write is at cycle 6 and the last (k=391) at cycle 1570.
- wr_en is high exactly one cycle per window. wr_addr increments by 1 per write, 0..391.
- DRAIN occupies cycles 1569..1570. rd_en=0 in DRAIN.
- done=1 only in cycle 1570, coincident with the last wr_en.
- busy is high for cycles 1..1570 and is 0 at cycle 1571 (IDLE).
- Throughput: one full pass every 1571 cycles with back-to-back starts.

## Test plan
- Ramp input, mem[a] = a: 392 writes. out[k] equals the address of (2i+1,2j+1), e.g. out[0]=29, out[13]=55, out[196]=813. done at cycle 1570 only.
- Signed extremes: all words = -32768 except one 32767 at (2i,2j+1) of each window: every wr_data = 32767. All words = -32768: every wr_data = -32768.
- Max in each window position: per-window place 5 at q = k mod 4 and -7 elsewhere: every wr_data = 5. This catches accumulator-load and final-element bugs.
- Protocol timing: check rd_en high exactly cycles 1..1568, first wr_en at cycle 6 with wr_addr=0, write spacing of 4 cycles, and busy low at cycle 1571.
- start pulses at cycles 100 and 1570: ignored, with no extra reads. start at 1571: second pass begins, rd_addr=0 at cycle 1572.
- rst at cycle 800: at cycle 801 all outputs are 0 and state is IDLE, with no done. A following start gives a clean full pass matching the ramp expectations.
